// File: rtl/ahb_sram_slave_ctrl.sv
// ahb_sram_slave_ctrl
//
// AHB-Lite slave front end for a single-port synchronous word RAM.
// Word reads take one wait state. Word writes complete with zero wait states.
// Byte and halfword writes run as a read-modify-write through an external
// store-merge stage. Illegal transfers get a two-cycle ERROR response.
//
// Ports
//   hclk, hreset        clock, synchronous active-high reset
//   hsel, hwrite, hready, haddr, htrans, hsize, hwdata
//                       AHB-Lite address/data phase inputs
//   hreadyout, hresp, hrdata
//                       AHB-Lite slave response
//   ram_en, ram_we, ram_addr, ram_wdata, ram_rdata
//                       single-port RAM; read data is valid one cycle after ram_en
//   mrg_hsize, mrg_read_data, mrg_wr_data, mrg_store_data
//                       store-merge stage: it puts the low byte/half of
//                       mrg_wr_data over mrg_read_data
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no data phase pending, ready for a new address phase
// RD_REQ  | RAM read issued, data phase stalled
// RD_DATA | RAM read data presented on hrdata, data phase completes
// WR_WORD | full-word write straight from hwdata, zero wait
// RMW_RD  | sub-word write: read old word and capture hwdata, stalled
// RMW_WR  | sub-word write: write the merged word back, completes
// ERR1    | first ERROR cycle (hreadyout low)
// ERR2    | second ERROR cycle (hreadyout high)

module ahb_sram_slave_ctrl #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  hsel,
    input  logic                  hwrite,
    input  logic                  hready,
    input  logic [31:0]           haddr,
    input  logic [1:0]            htrans,
    input  logic [2:0]            hsize,
    input  logic [31:0]           hwdata,
    output logic                  hreadyout,
    output logic                  hresp,
    output logic [31:0]           hrdata,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata,
    output logic [2:0]            mrg_hsize,
    output logic [31:0]           mrg_read_data,
    output logic [31:0]           mrg_wr_data,
    input  logic [31:0]           mrg_store_data
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_DATA,
        WR_WORD,
        RMW_RD,
        RMW_WR,
        ERR1,
        ERR2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [ADDR_WIDTH+1:0] haddr_q;
    logic [2:0]            hsize_q;
    logic [31:0]           wdata_q;
    logic [1:0]            off;

    logic accept_req;
    logic accept;
    logic ram_en_s;
    logic ram_we_s;

    // Rotate a word right by whole bytes. This moves the addressed lane down to bit 0.
    function automatic logic [31:0] rot_right(input logic [31:0] x, input logic [1:0] n);
        logic [31:0] r;
        case (n)
            2'd0:    r = x;
            2'd1:    r = {x[7:0],  x[31:8]};
            2'd2:    r = {x[15:0], x[31:16]};
            default: r = {x[23:0], x[31:24]};
        endcase
        return r;
    endfunction

    // Rotate a word left by whole bytes. This is the inverse of rot_right.
    function automatic logic [31:0] rot_left(input logic [31:0] x, input logic [1:0] n);
        logic [31:0] r;
        case (n)
            2'd0:    r = x;
            2'd1:    r = {x[23:0], x[31:24]};
            2'd2:    r = {x[15:0], x[31:16]};
            default: r = {x[7:0],  x[31:8]};
        endcase
        return r;
    endfunction

    // Pick the first data-phase state for a transfer that has been accepted.
    function automatic state_t decode(
        input logic [31:0] a,
        input logic [2:0]  s,
        input logic        w
    );
        logic   err;
        state_t nxt;
        err = 1'b0;
        if (s > 3'b010) begin
            err = 1'b1;
        end else if ((a >> (ADDR_WIDTH + 2)) != 32'd0) begin
            err = 1'b1;
        end else if ((s == 3'b001) && a[0]) begin
            err = 1'b1;
        end else if ((s == 3'b010) && (a[1:0] != 2'b00)) begin
            err = 1'b1;
        end
        if (err) begin
            nxt = ERR1;
        end else if (!w) begin
            nxt = RD_REQ;
        end else if (s == 3'b010) begin
            nxt = WR_WORD;
        end else begin
            nxt = RMW_RD;
        end
        return nxt;
    endfunction

    // Only NONSEQ and SEQ start a transfer. IDLE and BUSY are ignored.
    assign accept_req = hsel && hready && ((htrans == 2'b10) || (htrans == 2'b11));

    assign off = haddr_q[1:0];

    always_comb begin
        state_d   = IDLE;
        hreadyout = 1'b1;
        hresp     = 1'b0;
        hrdata    = 32'h0;
        ram_en_s  = 1'b0;
        ram_we_s  = 1'b0;
        ram_wdata = 32'h0;
        accept    = 1'b0;

        case (state_q)
            IDLE: begin
            end
            RD_REQ: begin
                hreadyout = 1'b0;
                ram_en_s  = 1'b1;
                state_d   = RD_DATA;
            end
            RD_DATA: begin
                hrdata = ram_rdata;
            end
            WR_WORD: begin
                ram_en_s  = 1'b1;
                ram_we_s  = 1'b1;
                ram_wdata = hwdata;
            end
            RMW_RD: begin
                hreadyout = 1'b0;
                ram_en_s  = 1'b1;
                state_d   = RMW_WR;
            end
            RMW_WR: begin
                ram_en_s  = 1'b1;
                ram_we_s  = 1'b1;
                ram_wdata = rot_left(mrg_store_data, off);
            end
            ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
                state_d   = ERR2;
            end
            ERR2: begin
                hresp = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // When a data phase completes, the next address phase can be accepted
        // in the same cycle.
        if (hreadyout && accept_req) begin
            accept  = 1'b1;
            state_d = decode(haddr, hsize, hwrite);
        end
    end

    // While reset is asserted the RAM strobes are held off. This keeps a reset
    // that lands in RMW_WR from committing a half-finished merge.
    assign ram_en = ram_en_s && !hreset;
    assign ram_we = ram_we_s && !hreset;

    assign ram_addr      = haddr_q[ADDR_WIDTH+1:2];
    assign mrg_hsize     = hsize_q;
    assign mrg_read_data = rot_right(ram_rdata, off);
    assign mrg_wr_data   = wdata_q >> {off, 3'b000};

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q <= IDLE;
            haddr_q <= '0;
            hsize_q <= 3'b000;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                haddr_q <= haddr[ADDR_WIDTH+1:0];
                hsize_q <= hsize;
            end
            if (state_q == RMW_RD) begin
                wdata_q <= hwdata;
            end
        end
    end

endmodule

// File: doc/ahb_sram_slave_ctrl.md
# ahb_sram_slave_ctrl

AHB-Lite slave controller that fronts a single-port synchronous word RAM and sequences every transfer: word reads, zero-wait word writes, and read-modify-write for byte/halfword writes. It feeds the downstream store-merge stage with a lane-rotated RAM word and write data. It consumes the merged word back, rotates it into place and writes it to RAM. It also generates HREADYOUT wait states and two-cycle ERROR responses.

## Interface
- ADDR_WIDTH, 10, word-address bits; RAM depth = 2**ADDR_WIDTH words
- hclk  in  1  clock; all logic rising-edge
- hreset  in  1  synchronous, active-high reset
- hsel, hwrite, hready  in  1 each  AHB select, direction, bus ready
- haddr  in  32  byte address; htrans  in  2; hsize  in  3; hwdata  in  32
- hreadyout  out  1; hresp  out  1 (0 OKAY, 1 ERROR); hrdata  out  32
- ram_en, ram_we  out  1 each; ram_addr  out  ADDR_WIDTH; ram_wdata  out  32; ram_rdata  in  32 (valid one cycle after ram_en)
- mrg_hsize  out  3; mrg_read_data, mrg_wr_data  out  32; mrg_store_data  in  32 (combinational merge: low byte/half of mrg_wr_data over mrg_read_data)

## Operation
- Accept: hsel & hready & htrans[1]. On accept, register haddr, hsize, hwrite; the next state is chosen by decode.
- Error decode, checked in order: hsize>3'b010; haddr[31:ADDR_WIDTH+2]!=0; hsize=001 with haddr[0]=1; hsize=010 with haddr[1:0]!=0. Any match sends the transfer to ERR1.
- IDLE/BUSY htrans, or hsel=0: no action, OKAY, zero wait.
- States and hreadyout:
  - IDLE: hreadyout 1.
  - RD_REQ: hreadyout 0; ram_en=1.
  - RD_DATA: hreadyout 1; hrdata=ram_rdata.
  - WR_WORD: hreadyout 1; ram_en=ram_we=1; ram_wdata=hwdata.
  - RMW_RD: hreadyout 0; ram_en=1; hwdata is captured into wdata_q.
  - RMW_WR: hreadyout 1; ram_en=ram_we=1; ram_wdata=rotl(mrg_store_data).
  - ERR1: hreadyout 0, hresp 1.
  - ERR2: hreadyout 1, hresp 1.
- Transitions:
  - Read → RD_REQ → RD_DATA.
  - Word write → WR_WORD.
  - Sub-word write → RMW_RD → RMW_WR.
  - Error → ERR1 → ERR2.
  - From any state with hreadyout=1: next state is the decode of a new accept that cycle, else IDLE.
- Lane steering, off=haddr_q[1:0]:
  - mrg_read_data = ram_rdata rotated right 8*off.
  - mrg_wr_data = wdata_q >> 8*off (logical shift).
  - ram_wdata = mrg_store_data rotated left 8*off.
  - mrg_hsize = hsize_q.
- Lane steering leaves untouched bytes bit-exact.
- ram_addr = haddr_q[ADDR_WIDTH+1:2] whenever ram_en=1.
- hrdata is 0 outside RD_DATA. Reads always return the full word, regardless of hsize.
- ERROR transfers never assert ram_en.

## Timing
- Reset values: state IDLE, hreadyout 1, hresp 0, hrdata 0, ram_en 0, ram_we 0, ram_addr 0, registered address/size/data 0.
- Latency by transfer type:
  - Read: 1 wait state.
  - Word write: 0 wait states; the RAM write occurs in the data-phase cycle.
  - Sub-word write: 1 wait state; the RAM write occurs in the second data-phase cycle.
  - Error: exactly 2 cycles.
- Pipelining: the next address phase is accepted in the same cycle a data phase completes (hreadyout=1). Back-to-back transfers run with no idle gap.
- Write followed by a read of the same address: the read returns the new data. The RAM write always happens in an earlier cycle than the following read's ram_en.
- During wait states, hwdata and the address inputs are ignored except in RMW_RD, which captures hwdata.
- Reset asserted mid-transfer: the next edge forces IDLE, and no RAM write is issued after that edge. A partially completed RMW leaves the RAM word unchanged.

## Test plan
- Reset: assert hreset 2 cycles in RMW_RD → hreadyout=1, hresp=0, ram_we=0, hrdata=0 the following cycle; RAM word unchanged.
- Word write 0xDEADBEEF @0x10, then read @0x10 → zero-wait write; read returns 0xDEADBEEF after exactly 1 wait state.
- Word @0x20=0x11223344.
  - Byte write 0xAA at 0x22 → RAM 0x11AA3344.
  - Halfword write 0xBEEF at 0x20 → RAM 0x11AABEEF.
  - Each of these writes takes 1 wait state.
- Errors, each giving ERR1/ERR2 (hreadyout 0 then 1, hresp 1 both cycles) with no ram_en:
  - hsize=011.
  - Halfword at 0x21.
  - Word at 0x1002 with ADDR_WIDTH=10.
- Back-to-back NONSEQ: word write, byte write, read to the same word → no idle cycles between transfers; read returns the merged value.
- IDLE/BUSY with hsel=1, and NONSEQ with hsel=0 → hreadyout 1, hresp 0, no RAM activity.
